// File: rtl/fp32_min_reduce_ctrl.sv
// rtl/fp32_min_reduce_ctrl.sv - sequential FP32 min-reduction controller over a valid/ready stream
module fp32_min_reduce_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  output logic [LEN_W-1:0] out_count_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [31:0]      min_out;

  // Shared FP32 min unit: an all-zero operand is skipped, otherwise a
  // sign-magnitude compare (NaN/Inf are ordered by their raw bits).
  function automatic logic [31:0] fp_min(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a == 32'h0)            r = b;
    else if (b == 32'h0)       r = a;
    else if (a[31] != b[31])   r = a[31] ? a : b;
    else if (!a[31])           r = (b[30:0] < a[30:0]) ? b : a;
    else                       r = (b[30:0] > a[30:0]) ? b : a;
    return r;
  endfunction

  // Min unit sees the running accumulator against the incoming element.
  always_comb min_out = fp_min(acc_q, in_data_i);

  // FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath registers: accumulator, remaining count, folded count, first flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q   <= 32'h0;
      rem_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = '0;
          first_d = 1'b1;
          if (len_i != '0) begin
            rem_d   = len_i;
            state_d = ACCUM;
          end else begin
            acc_d   = 32'h0;
            rem_d   = '0;
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          // The first element loads directly; later ones fold through min.
          acc_d   = first_q ? in_data_i : min_out;
          first_d = 1'b0;
          rem_d   = rem_q - 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign out_data_o  = acc_q;
  assign out_count_o = cnt_q;

endmodule

// File: doc/fp32_min_reduce_ctrl.md
Name: fp32_min_reduce_ctrl

Overview:
Sequential min-reduction controller for the TPU vector path. It accepts a job of LEN float32 elements over a valid/ready stream and folds them through one instance of the team's combinational FP32 `min` unit, using an accumulator register. It returns the single minimum on a valid/ready output. This lets pooling and normalisation stages share one min datapath instead of building a comparator tree.

Parameters:
LEN_W, 8, width of the job-length field (max job = 2^LEN_W - 1 elements)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that launches a job; sampled only in IDLE
len  input  LEN_W  element count for the job, latched on accepted start
busy  output  1  high from accepted start until the result handshake completes
in_valid  input  1  element present on in_data
in_ready  output  1  controller can take an element this cycle
in_data  input  32  IEEE-754 single-precision element
out_valid  output  1  result present on out_data
out_ready  input  1  consumer accepts the result
out_data  output  32  minimum of the job's elements
out_count  output  LEN_W  number of elements folded into out_data

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high. Reset values: state=IDLE, busy=0, in_ready=0, out_valid=0, out_data=32'h0, out_count=0, acc=0, remaining=0, first=1.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0.
  - start=1 and len!=0 -> latch remaining=len, set first=1, go to ACCUM; busy=1 the next cycle.
  - start=1 and len==0 -> go directly to DONE with out_data=32'h0 and out_count=0.
- ACCUM: in_ready=1, combinationally.
  - An element transfers on in_valid & in_ready.
  - For the first transfer: acc <= in_data and first <= 0. This load bypasses the min unit.
  - For each later transfer: acc <= min_out, where the min unit's inputA=acc and inputB=in_data.
  - Every transfer decrements remaining and increments the count.
  - The transfer with remaining==1 moves to DONE. out_valid rises the next cycle and out_data = the final acc value.
  - Throughput: one element per cycle. Latency: last element accepted at cycle t -> out_valid=1 at t+1.
  - Bubbles (in_valid=0) leave all state unchanged. There is no timeout.
- DONE: out_valid=1 and in_ready=0. out_data and out_count stay stable until out_valid & out_ready. On that handshake: next cycle IDLE, busy=0, out_valid=0.
- start while not in IDLE is ignored; it is not queued.
- start in the same cycle as the DONE handshake is ignored. The new job needs a start pulse in IDLE.
- Arithmetic follows the `min` unit exactly. That includes its rule that an all-zero operand (+0.0) is skipped, returning the other operand. Consequences:
  - A job of all +0.0 returns 32'h0.
  - A +0.0 element among nonzero elements does not become the result.
- NaN and Inf are not special-cased; they pass through the min unit unchanged.
- The controller does not normalise or round. out_data is the min unit's output, registered.
- Reset mid-job (ACCUM or DONE): the job is abandoned immediately, with no result. Outputs take their reset values asynchronously.
- out_count saturates at its LEN_W width. Because len is LEN_W bits, overflow cannot occur.

Test Plan:
- Basic fold: start with len=3, then elements 0x40400000 (3.0), 0xBFC00000 (-1.5), 0x40000000 (2.0) back-to-back -> out_valid exactly 1 cycle after the third transfer, out_data=0xBFC00000, out_count=3, busy falls 1 cycle after out_ready.
- Same sign, different exponents: len=2 with 0x41200000 (10.0), 0x3F000000 (0.5) -> out_data=0x3F000000. Then len=2 with 0xC1200000 (-10.0), 0xBF000000 (-0.5) -> out_data=0xC1200000.
- Bubbles and backpressure: len=4 with in_valid toggled every other cycle, and out_ready held low for 5 cycles after out_valid -> exactly 4 transfers. out_data and out_count hold stable while stalled. in_ready=0 throughout DONE.
- Boundary cases:
  - len=0 -> out_valid the cycle after start with out_data=0x0 and out_count=0.
  - len=1 with 0xC0A00000 -> out_data=0xC0A00000, bypassing the min unit.
- Ignored start: pulse start (len=7) during ACCUM of a len=2 job -> result still reflects 2 elements and remaining is unaffected.
- Reset mid-operation: assert reset asynchronously (between clock edges) during ACCUM after 2 of 5 elements -> all outputs take reset values immediately. Then a new len=1 job with 0x3F800000 -> out_data=0x3F800000, out_count=1.
